// File: rtl/csync_serration_generator.sv
// Composite sync generator: AND / XOR / serrated modes with
// on-the-fly line-period measurement and lock detection.
module csync_serration_generator #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = 1,
  parameter bit INVERT_OUT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [1:0]           mode,
  output logic                 csync,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] line_period
);

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH:0]   TOLV = (CNT_WIDTH+1)'(TOL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEAS,
    S_TRACK
  } state_t;

  logic [SYNC_STAGES-1:0] r_hs_sync;
  logic [SYNC_STAGES-1:0] r_vs_sync;
  logic                   r_hs_p;
  logic [CNT_WIDTH-1:0]   r_pos;
  logic [CNT_WIDTH-1:0]   r_hw;
  logic [CNT_WIDTH-1:0]   r_hs_width;
  logic [CNT_WIDTH-1:0]   r_line_period;
  logic                   r_locked;
  logic                   r_csync;
  state_t                 r_state;

  logic                   w_hs_s;
  logic                   w_vs_s;
  logic                   w_hs_fall;
  logic                   w_hs_rise;
  logic                   w_pos_sat;
  logic [CNT_WIDTH-1:0]   w_p;
  logic [CNT_WIDTH:0]     w_diff;
  logic [CNT_WIDTH:0]     w_abs;
  logic                   w_in_tol;
  logic [CNT_WIDTH-1:0]   w_thr;
  logic                   w_c_and;
  logic                   w_c_xor;
  logic                   w_c;
  state_t                 w_state_nxt;
  logic                   w_locked_nxt;
  logic [CNT_WIDTH-1:0]   w_period_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_sync <= '1;
      r_vs_sync <= '1;
      r_hs_p    <= 1'b1;
    end else begin
      r_hs_sync <= {r_hs_sync[SYNC_STAGES-2:0], hsync};
      r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], vsync};
      r_hs_p    <= w_hs_s;
    end
  end

  assign w_hs_s    = r_hs_sync[SYNC_STAGES-1];
  assign w_vs_s    = r_vs_sync[SYNC_STAGES-1];
  assign w_hs_fall = r_hs_p & ~w_hs_s;
  assign w_hs_rise = ~r_hs_p & w_hs_s;
  assign w_pos_sat = (r_pos == CMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos <= '0;
    end else if (w_hs_fall) begin
      r_pos <= '0;
    end else if (!w_pos_sat) begin
      r_pos <= r_pos + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hw       <= '0;
      r_hs_width <= '0;
    end else begin
      if (w_hs_fall) begin
        r_hw <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else if (!w_hs_s && (r_hw != CMAX)) begin
        r_hw <= r_hw + 1'b1;
      end
      if (w_hs_rise) begin
        r_hs_width <= r_hw;
      end
    end
  end

  // Period is measured in one extra bit so the signed gap never wraps.
  assign w_p      = r_pos + 1'b1;
  assign w_diff   = {1'b0, w_p} - {1'b0, r_line_period};
  assign w_abs    = w_diff[CNT_WIDTH] ? (~w_diff + 1'b1) : w_diff;
  assign w_in_tol = (w_abs <= TOLV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_locked      <= 1'b0;
      r_line_period <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_locked      <= w_locked_nxt;
      r_line_period <= w_period_nxt;
    end
  end

  // A saturated position means hsync went missing; it overrides any fall.
  always_comb begin
    w_state_nxt  = r_state;
    w_locked_nxt = r_locked;
    w_period_nxt = r_line_period;
    if (w_pos_sat) begin
      w_state_nxt  = S_IDLE;
      w_locked_nxt = 1'b0;
    end else if (w_hs_fall) begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_MEAS;
          w_locked_nxt = 1'b0;
        end
        S_MEAS: begin
          w_state_nxt  = S_TRACK;
          w_locked_nxt = 1'b0;
          w_period_nxt = w_p;
        end
        S_TRACK: begin
          w_locked_nxt = w_in_tol;
          w_period_nxt = w_p;
        end
        default: begin
          w_state_nxt  = S_IDLE;
          w_locked_nxt = 1'b0;
        end
      endcase
    end
  end

  assign w_thr = (r_hs_width >= r_line_period) ? '0
               : (r_line_period - r_hs_width);

  assign w_c_and = w_hs_s & w_vs_s;
  assign w_c_xor = w_vs_s ? w_hs_s : ~w_hs_s;

  always_comb begin
    w_c = w_c_and;
    unique case (1'b1)
      (mode == 2'd1): w_c = w_c_xor;
      (mode == 2'd2): begin
        if (w_vs_s) begin
          w_c = w_hs_s;
        end else if (r_locked) begin
          w_c = (r_pos >= w_thr);
        end else begin
          w_c = w_c_xor;
        end
      end
      default: w_c = w_c_and;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csync <= ~INVERT_OUT;
    end else begin
      r_csync <= w_c ^ INVERT_OUT;
    end
  end

  assign csync       = r_csync;
  assign locked      = r_locked;
  assign line_period = r_line_period;

endmodule

// File: tb/tb_csync_serration_generator.sv
// Directed bench for csync_serration_generator: pin-level csync
// scoreboard plus lock / period checks at line boundaries.
module tb_csync_serration_generator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hsync;
  logic       vsync;
  logic [1:0] mode;
  logic       csync;
  logic       locked;
  logic [7:0] line_period;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] q[$];
  int   falls;
  int   since;
  logic prev_hs;

  always #5 clk = ~clk;

  csync_serration_generator #(
    .CNT_WIDTH  (8),
    .SYNC_STAGES(2),
    .TOL        (1),
    .INVERT_OUT (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hsync      (hsync),
    .vsync      (vsync),
    .mode       (mode),
    .csync      (csync),
    .locked     (locked),
    .line_period(line_period)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected csync is derived from the pins; it appears 3 samples later.
  task automatic step(input logic hs, input logic vs);
    logic       e;
    logic       fell;
    logic       lk;
    logic [1:0] item;
    fell = prev_hs && !hs;
    if (fell) begin
      falls++;
      since = 0;
    end else if (since < 100000) begin
      since++;
    end
    prev_hs = hs;
    hsync   = hs;
    vsync   = vs;
    lk      = ((falls - (fell ? 1 : 0)) >= 3);
    case (mode)
      2'd1: e = vs ? hs : ~hs;
      2'd2: begin
        if (vs) e = hs;
        else if (lk) e = (since == 0) ? 1'b1 : ((since - 1) >= 32);
        else e = ~hs;
      end
      default: e = hs & vs;
    endcase
    q.push_back({1'b1, e});
    @(posedge clk);
    #1;
    if (q.size() >= 3) begin
      item = q.pop_front();
      if (item[1]) check("csync", {31'd0, csync}, {31'd0, item[0]});
    end
  endtask

  task automatic line(input int hi, input int lo, input logic vs);
    for (int k = 0; k < hi; k++) step(1'b1, vs);
    for (int k = 0; k < lo; k++) step(1'b0, vs);
  endtask

  task automatic lock_chk(input string tag,
                          input logic lk,
                          input logic [7:0] lp);
    check({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
    check({tag, "_period"}, {24'd0, line_period}, {24'd0, lp});
  endtask

  initial begin
    rst_n   = 1'b0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    mode    = 2'd0;
    prev_hs = 1'b1;
    falls   = 0;
    since   = 1000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csync", {31'd0, csync}, 32'd1);
    lock_chk("rst", 1'b0, 8'd0);
    rst_n = 1'b1;

    repeat (100) step(1'b1, 1'b1);
    check("idle_csync", {31'd0, csync}, 32'd1);
    lock_chk("idle", 1'b0, 8'd0);

    line(32, 8, 1'b1);
    lock_chk("m0_l1", 1'b0, 8'd0);
    line(32, 8, 1'b1);
    lock_chk("m0_l2", 1'b0, 8'd40);
    line(32, 8, 1'b1);
    lock_chk("m0_l3", 1'b1, 8'd40);

    mode = 2'd1;
    line(32, 8, 1'b0);
    line(32, 8, 1'b0);
    line(32, 8, 1'b1);
    line(32, 8, 1'b1);
    lock_chk("m1", 1'b1, 8'd40);

    mode = 2'd0;
    line(33, 8, 1'b1);
    lock_chk("jit41", 1'b1, 8'd41);
    line(35, 8, 1'b1);
    lock_chk("jit43a", 1'b0, 8'd43);
    line(35, 8, 1'b1);
    lock_chk("jit43b", 1'b1, 8'd43);
    line(32, 8, 1'b1);
    lock_chk("jit40a", 1'b0, 8'd40);
    line(32, 8, 1'b1);
    lock_chk("jit40b", 1'b1, 8'd40);

    repeat (300) step(1'b1, 1'b1);
    lock_chk("loss", 1'b0, 8'd40);
    line(32, 8, 1'b1);
    line(32, 8, 1'b1);
    lock_chk("resume2", 1'b0, 8'd40);
    repeat (3) line(32, 8, 1'b1);
    lock_chk("resume5", 1'b1, 8'd40);

    repeat (10) step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    check("pre_rst_csync", {31'd0, csync}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_csync", {31'd0, csync}, 32'd1);
    lock_chk("async_rst", 1'b0, 8'd0);
    q.delete();
    falls   = 0;
    since   = 1000;
    prev_hs = 1'b1;
    hsync   = 1'b1;
    vsync   = 1'b0;
    mode    = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (20) step(1'b1, 1'b0);
    line(32, 8, 1'b0);
    line(32, 8, 1'b0);
    lock_chk("m2_unlk", 1'b0, 8'd40);
    repeat (4) line(32, 8, 1'b0);
    lock_chk("m2_lk", 1'b1, 8'd40);
    line(32, 8, 1'b1);
    line(32, 8, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    check("end_csync", {31'd0, csync}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
